// File: rtl/mul16_seq.sv
// rtl/mul16_seq.sv - sequential 16x16 shift-and-add multiplier (low 16 product bits)
// add16 is the library adder; mul16_seq owns the single instance used for accumulation.

module add16 (
  output logic [15:0] sum,
  input  logic [15:0] a,
  input  logic [15:0] b
);
  assign sum = a + b;
endmodule

module mul16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [15:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] product_q, product_d;
  logic [15:0] sum;

  // Carry out of bit 15 is dropped on purpose: the result is taken mod 2^16.
  add16 u_add16 (
    .sum (sum),
    .a   (acc_q),
    .b   (mcand_q)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = 16'h0000;
          cnt_d    = 5'd0;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        if (mplier_q[0]) begin
          acc_d = sum;
        end
        mcand_d  = {mcand_q[14:0], 1'b0};
        mplier_d = {1'b0, mplier_q[15:1]};
        cnt_d    = cnt_q + 5'd1;
        // All 16 iterations always run; no early exit when the multiplier empties.
        if (cnt_q == 5'd15) begin
          product_d = mplier_q[0] ? sum : acc_q;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= 16'h0000;
      mplier_q  <= 16'h0000;
      acc_q     <= 16'h0000;
      cnt_q     <= 5'd0;
      product_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = product_q;
endmodule

// File: tb/tb_mul16_seq.sv
// tb/tb_mul16_seq.sv - scoreboard bench for mul16_seq against a plain-arithmetic model

module tb_mul16_seq;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int          n_cmp;
  int          n_err;
  logic [15:0] exp_q[$];

  mul16_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_mul(input logic [15:0] x, input logic [15:0] y);
    int unsigned full;
    full = int'(x) * int'(y);
    return full[15:0];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expected product.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_done_exclusive", {15'd0, busy & done}, 16'h0000);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 16'h0001, 16'h0000);
        end else begin
          chk("product", product, exp_q.pop_front());
        end
      end
    end
  end

  // One operation from accept to the cycle after done; poke>0 raises start
  // with all-ones operands at edge E<poke>, which the DUT must ignore.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input int poke);
    @(negedge clk);
    start = 1'b1; a = x; b = y;
    @(posedge clk);
    exp_q.push_back(model_mul(x, y));
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      chk("busy_timeline", {15'd0, busy}, {15'd0, k < 16});
      chk("done_timeline", {15'd0, done}, {15'd0, k == 16});
      if (k + 1 == poke) begin
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
      end else begin
        start = 1'b0; a = 16'($urandom); b = 16'($urandom);
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk("done_cleared", {15'd0, done}, 16'h0000);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = 16'h0000;
    b = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_busy", {15'd0, busy}, 16'h0000);
      chk("reset_done", {15'd0, done}, 16'h0000);
      chk("reset_product", product, 16'h0000);
    end

    run_op(16'h0003, 16'h0005, 0);
    chk("basic_3x5_hold", product, 16'h000F);
    run_op(16'h0000, 16'h1234, 0);
    run_op(16'hFFFF, 16'hFFFF, 0);
    run_op(16'hFFFE, 16'h0003, 0);
    run_op(16'h0100, 16'h0100, 0);
    run_op(16'h00FF, 16'h0101, 0);
    run_op(16'h0007, 16'h0006, 5);
    chk("ignored_start_hold", product, 16'h002A);

    // Back-to-back with start held high across the DONE cycle.
    @(negedge clk);
    start = 1'b1; a = 16'h0002; b = 16'h0009;
    @(posedge clk);
    exp_q.push_back(model_mul(16'h0002, 16'h0009));
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) begin
        a = 16'h0004; b = 16'h0004;
      end
    end
    chk("b2b_first_done", {15'd0, done}, 16'h0001);
    @(posedge clk);
    exp_q.push_back(model_mul(16'h0004, 16'h0004));
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
      if (k < 16) begin
        chk("b2b_product_held", product, 16'h0012);
        chk("b2b_busy", {15'd0, busy}, 16'h0001);
      end else begin
        chk("b2b_second_done", {15'd0, done}, 16'h0001);
      end
    end

    // Reset mid-operation: nothing is queued, so any stale done is flagged.
    @(negedge clk);
    start = 1'b1; a = 16'h0005; b = 16'h0005;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {15'd0, busy}, 16'h0000);
    chk("midrst_done", {15'd0, done}, 16'h0000);
    chk("midrst_product", product, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0001, 16'h0001, 0);

    for (int i = 0; i < 20; i++) begin
      run_op(16'($urandom), 16'($urandom), (i % 4 == 0) ? int'($urandom_range(1, 15)) : 0);
    end

    repeat (20) @(negedge clk);
    chk("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
